// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, format classification and immediate range helper.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
// Contents: opcode localparams, instr_fmt_t, out_state_t, fmt_of(), imm_fits12().
package riscv_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_BAD
    } instr_fmt_t;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } out_state_t;

    function automatic instr_fmt_t fmt_of(input logic [6:0] opcode);
        instr_fmt_t fmt;
        case (opcode)
            OP_IMM, OP_LOAD: fmt = FMT_I;
            OP_STORE:        fmt = FMT_S;
            OP_REG:          fmt = FMT_R;
            default:         fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

    // Signed 12-bit range check: bits [31:11] must all be copies of the sign.
    function automatic logic imm_fits12(input logic [31:0] imm);
        return (imm[31:11] == 21'h0) || (imm[31:11] == 21'h1F_FFFF);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs decoded fields into an RV32I R/I/S word and flags range or opcode errors.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to sample.
// Ports: opcode/rd/rs1/rs2/funct3/funct7/imm in; instr (32b word) and err out.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    instr_fmt_t fmt;
    logic       imm_ok;

    assign fmt    = fmt_of(opcode);
    assign imm_ok = imm_fits12(imm);

    always_comb begin
        instr = 32'h0000_0000;
        err   = 1'b0;
        case (fmt)
            FMT_I: begin
                // Out-of-range immediates still produce a word, truncated to 12 bits.
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                err   = ~imm_ok;
            end
            FMT_S: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err   = ~imm_ok;
            end
            FMT_R: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            default: begin
                instr = 32'h0000_0000;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: valid/ready field stream in, packed RV32I word + write address out.
// Latency: 1 cycle from input handshake to out_valid.
// Backpressure: single output register; in_ready = EMPTY | out_ready, full rate when out_ready held high.
// Ports: clk/rst; in_valid/in_ready + in_* fields; out_valid/out_ready, out_instr, out_addr, out_err; err_count.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    out_state_t state_q;
    out_state_t state_d;
    logic       in_hs;
    logic       out_hs;
    logic [31:0] pack_instr;
    logic        pack_err;

    instr_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_EMPTY) | out_ready;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_hs) state_d = ST_FULL;
            end
            ST_FULL: begin
                // While FULL an input handshake implies an output handshake,
                // so only the drain-without-refill case leaves FULL.
                if (out_hs && !in_hs) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_instr <= 32'h0000_0000;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_count <= 16'h0000;
        end else begin
            if (in_hs) begin
                out_instr <= pack_instr;
                out_err   <= pack_err;
            end
            // Address tracks the word currently presented; natural 32-bit wrap.
            if (out_hs) begin
                out_addr <= out_addr + 32'd4;
            end
            if (out_hs && out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder with hand-computed expected words and addresses.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises a 3-cycle out_ready stall and reset while FULL and stalled.
module tb_instr_encoder;

    typedef struct {
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_addr;
    logic        out_err;
    logic [15:0] err_count;

    logic        in_valid_h, in_ready_h;
    logic        out_valid_h, out_ready_h;
    logic [31:0] out_instr_h, out_addr_h;
    logic        out_err_h;
    logic [15:0] err_count_h;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[10];

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    instr_encoder #(.BASE_ADDR(32'hFFFF_FFF8)) u_dut_hi (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_h),
        .in_ready  (in_ready_h),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid_h),
        .out_ready (out_ready_h),
        .out_instr (out_instr_h),
        .out_addr  (out_addr_h),
        .out_err   (out_err_h),
        .err_count (err_count_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic [31:0] ei, input logic ee);
        vec_t v;
        v.opc = opc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.exp_instr = ei; v.exp_err = ee;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_opcode = v.opc;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // addi xk, x0, k for k = 1..4
    function automatic vec_t addi_k(input int k);
        logic [31:0] w;
        case (k)
            1:       w = 32'h0010_0093;
            2:       w = 32'h0020_0113;
            3:       w = 32'h0030_0193;
            default: w = 32'h0040_0213;
        endcase
        return mkv(7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k), w, 1'b0);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_cnt;

        // rd/rs2/funct7 set to junk where the format ignores them.
        vecs[0] = mkv(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0050_0093, 1'b0);
        vecs[1] = mkv(7'h23, 5'd9, 5'd1, 5'd2, 3'd2, 7'h7F, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
        vecs[2] = mkv(7'h03, 5'd3, 5'd0, 5'd5, 3'd2, 7'h55, 32'd8,         32'h0080_2183, 1'b0);
        vecs[3] = mkv(7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'h00, 32'h1234_5678, 32'h0073_02B3, 1'b0);
        vecs[4] = mkv(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h8000_0013, 1'b1);
        vecs[5] = mkv(7'h6F, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0,         32'h0000_0000, 1'b1);
        vecs[6] = mkv(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
        vecs[7] = mkv(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,      32'h7FF0_0013, 1'b0);
        vecs[8] = mkv(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0,         32'h4031_00B3, 1'b0);
        vecs[9] = mkv(7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'h00, 32'h0000_1000, 32'h0000_2023, 1'b1);

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_valid_h = 1'b0;
        out_ready_h = 1'b1;
        drive(vecs[0]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_instr", out_instr,      32'h0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_out_addr",  out_addr,       32'h0);
        chk("rst_err_count", 32'(err_count), 32'd0);

        // Back-to-back stream, out_ready high: word i at address 4*i.
        exp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_err", i),   32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_addr", i),  out_addr, 32'(i * 4));
            chk($sformatf("v%0d_cnt", i),   32'(err_count), 32'(exp_cnt));
            if (vecs[i].exp_err) exp_cnt++;
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_addr",  out_addr, 32'd40);
        chk("drain_cnt",   32'(err_count), 32'd3);

        // Stall test: 4 words, out_ready low for 3 cycles while word 2 is shown.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(addi_k(1));
        in_valid = 1'b1;
        tick();
        chk("st_w1_instr", out_instr, 32'h0010_0093);
        chk("st_w1_addr",  out_addr,  32'd0);
        drive(addi_k(2));
        tick();
        chk("st_w2_instr", out_instr, 32'h0020_0113);
        chk("st_w2_addr",  out_addr,  32'd4);
        drive(addi_k(3));
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("stall%0d_valid", k),    32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_instr", k),    out_instr, 32'h0020_0113);
            chk($sformatf("stall%0d_addr", k),     out_addr, 32'd4);
            chk($sformatf("stall%0d_err", k),      32'(out_err), 32'd0);
            if (k < 3) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("st_w3_instr", out_instr, 32'h0030_0193);
        chk("st_w3_addr",  out_addr,  32'd8);
        drive(addi_k(4));
        tick();
        chk("st_w4_instr", out_instr, 32'h0040_0213);
        chk("st_w4_addr",  out_addr,  32'd12);
        in_valid = 1'b0;
        tick();
        chk("st_end_valid", 32'(out_valid), 32'd0);
        chk("st_end_addr",  out_addr, 32'd16);

        // Reset while FULL and stalled, with a pending input that must be dropped.
        drive(vecs[5]);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_cnt", 32'(err_count), 32'd1);
        drive(vecs[0]);
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("pre_rst_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("post_rst_valid",    32'(out_valid), 32'd0);
        chk("post_rst_addr",     out_addr, 32'h0);
        chk("post_rst_cnt",      32'(err_count), 32'd0);
        chk("post_rst_instr",    out_instr, 32'h0);
        chk("post_rst_err",      32'(out_err), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Address wrap on the high-base instance.
        out_ready = 1'b1;
        chk("hi_rst_addr", out_addr_h, 32'hFFFF_FFF8);
        drive(addi_k(1));
        in_valid_h = 1'b1;
        tick();
        chk("hi_w1_addr",  out_addr_h, 32'hFFFF_FFF8);
        chk("hi_w1_instr", out_instr_h, 32'h0010_0093);
        drive(addi_k(2));
        tick();
        chk("hi_w2_addr",  out_addr_h, 32'hFFFF_FFFC);
        drive(addi_k(3));
        tick();
        chk("hi_w3_addr",  out_addr_h, 32'h0000_0000);
        chk("hi_w3_instr", out_instr_h, 32'h0030_0193);
        in_valid_h = 1'b0;
        tick();
        chk("hi_end_valid", 32'(out_valid_h), 32'd0);
        chk("hi_end_addr",  out_addr_h, 32'h0000_0004);
        chk("hi_end_cnt",   32'(err_count_h), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and sequencer for the RISC-V core's test and boot path: accepts decoded instruction fields (opcode, registers, funct fields, 32-bit immediate) over a valid/ready stream and packs them into 32-bit RV32I words for R, I and S formats. It is the inverse of the core's immediate generator and feeds the instruction-memory write port, which holds a word-address counter. One registered output stage gives full throughput under backpressure. Immediates that do not fit the format, and unsupported opcodes, are flagged per word and counted.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: first write address after reset; must be 4-byte aligned.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder can accept this cycle.
- `in_opcode` in 7: opcode bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register indices.
- `in_funct3` in 3; `in_funct7` in 7.
- `in_imm` in 32: sign-extended immediate value.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_instr` out 32: encoded instruction.
- `out_addr` out 32: write address for `out_instr`.
- `out_err` out 1: the current word has an immediate range error or an unsupported opcode.
- `err_count` out 16: number of emitted words with `out_err`=1; saturates at 16'hFFFF.

## Operation
- Format is selected by `in_opcode`:
  - I: 7'b0010011 and 7'b0000011.
  - S: 7'b0100011.
  - R: 7'b0110011.
  - Any other opcode is unsupported.
- I word: {imm[11:0], rs1, funct3, rd, opcode}. `in_rs2` and `in_funct7` are ignored.
- S word: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. `in_rd` and `in_funct7` are ignored.
- R word: {funct7, rs2, rs1, funct3, rd, opcode}. `in_imm` is ignored and never raises a range error.
- Range check for I and S: `in_imm` must lie in the signed 12-bit range −2048..2047, i.e. bits [31:11] all equal.
  - On violation the word is still emitted, with the field truncated to imm[11:0], and `out_err`=1.
- Unsupported opcode: `out_instr`=32'h0000_0000, `out_err`=1.
- Address: `out_addr` starts at `BASE_ADDR` and advances by 4 on each output handshake (`out_valid & out_ready`). It wraps from 32'hFFFF_FFFC to 0 with no flag.
- `err_count` increments on each output handshake with `out_err`=1, and holds at 16'hFFFF.
- Output stage state machine:
  - EMPTY: `out_valid`=0. An input handshake moves it to FULL.
  - FULL: `out_valid`=1. On output handshake with a simultaneous input handshake, stay FULL and load the new word. On output handshake alone, go to EMPTY. With no output handshake, hold.
- `in_ready` = EMPTY | `out_ready` (combinational pass-through of `out_ready`).
- While FULL and `out_ready`=0, `out_instr`, `out_addr` and `out_err` are stable.

## Timing
- Latency: 1 cycle. Fields accepted at edge N appear with `out_valid`=1 after edge N.
- Throughput: 1 word per cycle with `out_ready` held high.
- Reset applies at the next rising edge and overrides any handshake in that cycle; an in-flight word is discarded. Reset values:
  - state EMPTY, `out_valid`=0, `out_instr`=0, `out_err`=0.
  - `out_addr`=`BASE_ADDR`, `err_count`=0.
  - `in_ready`=1 in the cycle after reset.
- Input fields are don't-care when `in_valid`=0. Only the handshake-cycle values are sampled.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants `OP_IMM`=7'b0010011, `OP_LOAD`=7'b0000011, `OP_STORE`=7'b0100011, `OP_REG`=7'b0110011.
  - enum `instr_fmt_t` {FMT_R, FMT_I, FMT_S, FMT_BAD}.
  - The immediate generator uses the same constants.
- One combinational sub-module, `instr_pack`: takes opcode, fields and imm, and returns the word and the error bit. It is unit-testable against the immediate generator by round trip (immediate generator applied to `instr_pack` output returns the immediate for in-range values).
- The top holds the output register, state, address counter and error counter.

## Test plan
- addi x1,x0,5 (opcode 0010011, rd=1, rs1=0, f3=0, imm=5) → `out_instr`=32'h0050_0093, `out_addr`=`BASE_ADDR`, `out_err`=0.
- sw x2,−4(x1) (opcode 0100011, rs1=1, rs2=2, f3=010, imm=32'hFFFF_FFFC) → 32'hFE20_AE23. lw x3,8(x0) → 32'h0080_2183. add x5,x6,x7 → 32'h0073_02B3.
- addi with imm=2048, then opcode 7'b1101111 → words 32'h8000_0013 with `out_err`=1, then 32'h0 with `out_err`=1; `err_count`=2 after both handshakes.
- Stream of 4 words, `out_ready` low for 3 cycles on word 2:
  - word 2 outputs stable during the stall; `in_ready`=0 during the stall.
  - addresses `BASE_ADDR` +0, 4, 8, 12; no word lost or duplicated.
- `BASE_ADDR`=32'hFFFF_FFF8, 3 words → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst` asserted while FULL with `out_ready`=0 → next cycle `out_valid`=0, `out_addr`=`BASE_ADDR`, `err_count`=0, `in_ready`=1.
